// File: rtl/led_seq_ctrl.sv
// ============================================================================
// led_seq_ctrl
//
// Purpose:
//   Sequencing controller for an LED pattern engine. A free-running prescaler
//   produces STEP pulses whose period is set by the SPEED index. Three
//   debounced request pulses change the direction (MODE_REQ) and the speed
//   (SPEED_REQ), and toggle run/pause (PAUSE_REQ). A direction change also
//   sends the pattern engine back to position 0 through POSCLR.
//
// Parameters:
//   PRESC_W  prescaler width in bits (4..32). At SPEED = s the step period
//            is 2^(PRESC_W - s) cycles.
//   SWEEPS   complete sweeps per automatic direction advance (1..15). It is
//            only used when the auto-cycle feature is compiled in.
//
// Ports:
//   CLK        in   1  system clock; all state changes on its rising edge
//   RST        in   1  synchronous active-high reset
//   MODE_REQ   in   1  single-cycle pulse: advance direction 0->1->2->0
//   SPEED_REQ  in   1  single-cycle pulse: advance speed 0->1->2->3->0
//   PAUSE_REQ  in   1  single-cycle pulse: toggle run/pause
//   STEP       out  1  single-cycle pulse: advance the pattern one position
//   POSCLR     out  1  single-cycle pulse: return the pattern to position 0
//   DIR        out  2  0 = BOTH (6 steps/sweep), 1 = L2R, 2 = R2L (4 steps)
//   SPEED      out  2  speed index, 0 = slowest, 3 = fastest
//   RUN        out  1  1 = running, 0 = paused
//
// Configuration:
//   LED_SEQ_AUTO_CYCLE_EN  when defined, STEP pulses are counted into sweeps
//                          and the direction advances by itself after SWEEPS
//                          complete sweeps. When undefined, the step and
//                          sweep counters are not built and DIR only changes
//                          on MODE_REQ or RST.
//
// FSM states:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_RUN   | prescaler counts, STEP pulses are issued
//   ST_PAUSE | prescaler and sweep counters hold, STEP stays low
// ============================================================================
module led_seq_ctrl #(
    parameter int PRESC_W = 25,
    parameter int SWEEPS  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MODE_REQ,
    input  logic       SPEED_REQ,
    input  logic       PAUSE_REQ,
    output logic       STEP,
    output logic       POSCLR,
    output logic [1:0] DIR,
    output logic [1:0] SPEED,
    output logic       RUN
);

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_ONES = '1;

    state_t             state;
    state_t             state_nxt;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_nxt;
    logic [PRESC_W-1:0] tc_mask;
    logic               step_tc;
    logic               any_req;
    logic               auto_adv;
    logic               advance;
    logic               step_nxt;
    logic               posclr_nxt;
    logic [1:0]         dir_nxt;
    logic [1:0]         speed_nxt;

    // Terminal condition: the low (PRESC_W - SPEED) bits are all ones.
    assign tc_mask = PRESC_ONES >> SPEED;
    assign step_tc = ((presc_q & tc_mask) == tc_mask);

    assign any_req = MODE_REQ | SPEED_REQ | PAUSE_REQ;

    // A manual request and an automatic advance landing together still move
    // DIR by exactly one position.
    assign advance = MODE_REQ | auto_adv;

    assign RUN = (state == ST_RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_RUN;
            presc_q <= '0;
            STEP    <= 1'b0;
            POSCLR  <= 1'b0;
            DIR     <= 2'd0;
            SPEED   <= 2'd0;
        end else begin
            state   <= state_nxt;
            presc_q <= presc_nxt;
            STEP    <= step_nxt;
            POSCLR  <= posclr_nxt;
            DIR     <= dir_nxt;
            SPEED   <= speed_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        presc_nxt  = presc_q;
        dir_nxt    = DIR;
        speed_nxt  = SPEED;
        posclr_nxt = 1'b0;
        step_nxt   = 1'b0;

        if (PAUSE_REQ) begin
            state_nxt = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
        end

        if (advance) begin
            posclr_nxt = 1'b1;
            case (DIR)
                2'd0:    dir_nxt = 2'd1;
                2'd1:    dir_nxt = 2'd2;
                default: dir_nxt = 2'd0;
            endcase
        end

        if (SPEED_REQ) begin
            speed_nxt = SPEED + 2'd1;
        end

        // Clearing wins over holding, so a request made while paused still
        // restarts the step interval from zero.
        if (advance || SPEED_REQ) begin
            presc_nxt = '0;
        end else if (state == ST_RUN) begin
            presc_nxt = presc_q + PRESC_W'(1);
        end

        // Any request in the terminal cycle swallows that step; a pending
        // POSCLR always beats a STEP.
        step_nxt = (state == ST_RUN) && step_tc && !any_req && !advance;
    end

`ifdef LED_SEQ_AUTO_CYCLE_EN
    logic [2:0] step_cnt;
    logic [3:0] sweep_cnt;
    logic [2:0] sweep_last;

    assign sweep_last = (DIR == 2'd0) ? 3'd5 : 3'd3;

    // The sweep that reaches SWEEPS is acted on in the following cycle, so
    // the final STEP of the last sweep is issued before POSCLR.
    assign auto_adv = (state == ST_RUN) && (sweep_cnt == 4'(SWEEPS));

    always_ff @(posedge CLK) begin
        if (RST) begin
            step_cnt  <= '0;
            sweep_cnt <= '0;
        end else if (advance) begin
            step_cnt  <= '0;
            sweep_cnt <= '0;
        end else if (step_nxt) begin
            if (step_cnt == sweep_last) begin
                step_cnt  <= '0;
                sweep_cnt <= sweep_cnt + 4'd1;
            end else begin
                step_cnt  <= step_cnt + 3'd1;
            end
        end
    end
`else
    assign auto_adv = 1'b0;
`endif

endmodule
